// File: rtl/ksa_swap_s_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rc4_pkg
// Purpose  : Shared RC4 definitions: S-box size, key-length defaults, the
//            key-scheduling state encoding and MSB-first key byte extraction.
// Revision : 1.0 - initial release
// ============================================================================
package rc4_pkg;

  // Number of entries in the RC4 permutation table
  localparam int S_SIZE = 256;

  // Key length used when a stage is instantiated without an override
  localparam int KEY_BYTES_DEFAULT = 3;

  // Widest key that the byte extraction helper accepts
  localparam int KEY_BYTES_MAX = 32;

  // Key-scheduling sequencer states, one per cycle of a 6-cycle iteration
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_I = 3'd1,
    ST_WT_I = 3'd2,
    ST_RD_J = 3'd3,
    ST_WT_J = 3'd4,
    ST_WR_I = 3'd5,
    ST_WR_J = 3'd6,
    ST_DONE = 3'd7
  } ksa_state_t;

  // Width of a counter that indexes key bytes; never narrower than one bit
  function automatic int kidx_width(input int key_bytes);
    return (key_bytes > 1) ? $clog2(key_bytes) : 1;
  endfunction

  // Byte idx of a key whose byte 0 sits in the most significant position.
  // The key is passed zero-extended to the widest supported length.
  function automatic logic [7:0] key_byte(
    input logic [8*KEY_BYTES_MAX-1:0] key,
    input int                         idx,
    input int                         key_bytes
  );
    int pos;
    pos = 8 * (key_bytes - 1 - idx);
    return key[pos +: 8];
  endfunction

endpackage : rc4_pkg
`default_nettype wire

// File: rtl/ksa_swap_s_mem_if.sv
`default_nettype none
// ============================================================================
// Interface : ksa_swap_s_mem_if
// Purpose   : Control handshake and s_memory port of the RC4 key-scheduling
//             stage. The master side is the task top level (controller plus
//             memory mux); the slave side is the key-scheduling stage.
// Revision  : 1.0 - initial release
// ============================================================================
interface ksa_swap_s_mem_if
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) ();

  logic                   start;
  logic [8*KEY_BYTES-1:0] secret_key;
  logic [7:0]             mem_q;
  logic [7:0]             mem_address;
  logic [7:0]             mem_data;
  logic                   mem_wren;
  logic                   busy;
  logic                   done;

  modport master (
    output start,
    output secret_key,
    output mem_q,
    input  mem_address,
    input  mem_data,
    input  mem_wren,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  secret_key,
    input  mem_q,
    output mem_address,
    output mem_data,
    output mem_wren,
    output busy,
    output done
  );

endinterface : ksa_swap_s_mem_if
`default_nettype wire

// File: rtl/ksa_swap_s_mem_key_sel.sv
`default_nettype none
// ============================================================================
// Module   : rc4_key_byte_sel
// Purpose  : Combinational selection of one key byte (byte 0 = MSB byte).
//            Shared by the key-scheduling and PRGA stages.
// Revision : 1.0 - initial release
// ============================================================================
module rc4_key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
  parameter int KIDX_W    = kidx_width(KEY_BYTES)
) (
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [KIDX_W-1:0]      idx,
  output logic [7:0]             sel_byte
);

  logic [8*KEY_BYTES_MAX-1:0] w_key_ext;

  // Place the key in the low bytes of the widest key format
  always_comb begin
    w_key_ext                  = '0;
    w_key_ext[8*KEY_BYTES-1:0] = key;
  end

  assign sel_byte = key_byte(w_key_ext, int'(idx), KEY_BYTES);

endmodule : rc4_key_byte_sel
`default_nettype wire

// File: rtl/ksa_swap_s_mem.sv
`default_nettype none
// ============================================================================
// Module   : ksa_swap_s_mem
// Purpose  : RC4 key-scheduling pass over an initialised s_memory. For
//            i = 0..255: j += s[i] + key[i mod KEY_BYTES]; swap s[i], s[j].
//            Each iteration is read i, read j, write i, write j (6 cycles)
//            against a memory with a registered address and 1-cycle read.
// Revision : 1.0 - initial release
// ============================================================================
module ksa_swap_s_mem
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  ksa_swap_s_mem_if.slave  bus
);

  localparam int KIDX_W = kidx_width(KEY_BYTES);

  ksa_state_t             r_state;
  logic [7:0]             r_i;
  logic [7:0]             r_j;
  logic [KIDX_W-1:0]      r_kidx;
  logic [7:0]             r_si;
  logic [7:0]             r_sj;
  logic [8*KEY_BYTES-1:0] r_key;

  logic [7:0]             w_key_byte;
  logic [7:0]             w_mem_address;
  logic [7:0]             w_mem_data;
  logic                   w_mem_wren;
  logic                   w_busy;
  logic                   w_done;

  rc4_key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .KIDX_W    (KIDX_W)
  ) u_key_sel (
    .key      (r_key),
    .idx      (r_kidx),
    .sel_byte (w_key_byte)
  );

  // Sequencer: latch key on start, then walk the read/read/write/write loop.
  // The j update uses the s[i] value arriving on mem_q in WT_I, so RD_J
  // already addresses the new j.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_kidx  <= '0;
      r_si    <= '0;
      r_sj    <= '0;
      r_key   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_key   <= bus.secret_key;
            r_i     <= '0;
            r_j     <= '0;
            r_kidx  <= '0;
            r_state <= ST_RD_I;
          end
        end
        ST_RD_I: r_state <= ST_WT_I;
        ST_WT_I: begin
          r_si    <= bus.mem_q;
          r_j     <= r_j + bus.mem_q + w_key_byte;
          r_state <= ST_RD_J;
        end
        ST_RD_J: r_state <= ST_WT_J;
        ST_WT_J: begin
          r_sj    <= bus.mem_q;
          r_state <= ST_WR_I;
        end
        ST_WR_I: r_state <= ST_WR_J;
        ST_WR_J: begin
          if (r_i == 8'(S_SIZE - 1)) begin
            r_state <= ST_DONE;
          end else begin
            r_i     <= r_i + 8'd1;
            r_kidx  <= (r_kidx == KIDX_W'(KEY_BYTES - 1)) ? '0 : r_kidx + 1'b1;
            r_state <= ST_RD_I;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port decode: addresses only in the read/write slots, zero elsewhere.
  // When i == j both writes carry the same byte, leaving s unchanged.
  always_comb begin
    w_mem_address = '0;
    w_mem_data    = '0;
    w_mem_wren    = 1'b0;
    case (r_state)
      ST_RD_I: w_mem_address = r_i;
      ST_RD_J: w_mem_address = r_j;
      ST_WR_I: begin
        w_mem_address = r_i;
        w_mem_data    = r_sj;
        w_mem_wren    = 1'b1;
      end
      ST_WR_J: begin
        w_mem_address = r_j;
        w_mem_data    = r_si;
        w_mem_wren    = 1'b1;
      end
      default: begin
        w_mem_address = '0;
        w_mem_data    = '0;
        w_mem_wren    = 1'b0;
      end
    endcase
  end

  // Status flags: busy spans the working states, done is the DONE state
  always_comb begin
    w_busy = (r_state != ST_IDLE) && (r_state != ST_DONE);
    w_done = (r_state == ST_DONE);
  end

  assign bus.mem_address = w_mem_address;
  assign bus.mem_data    = w_mem_data;
  assign bus.mem_wren    = w_mem_wren;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;

endmodule : ksa_swap_s_mem
`default_nettype wire
